// File: rtl/pipelined_ripple_carry_adder.sv
// Pipelined WIDTH-bit ripple adder/subtractor split into STAGES carry-registered
// segments, with a valid/ready handshake and a single global stall.
module pipelined_ripple_carry_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEGP = SEG + 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c_first  = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             c_src, v_src;
    logic [SEG:0]     seg_sum;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = c_first;
      assign v_src = in_valid;
    end else begin : g_body
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign s_src = s_q[k-1];
      assign c_src = c_q[k-1];
      assign v_src = v_q[k-1];
    end

    assign seg_sum = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]} + SEGP'(c_src);
    // Bits above this segment are still zero in s_src, so OR-ing in the new slice suffices.
    assign s_d[k] = s_src | (WIDTH'(seg_sum[SEG-1:0]) << (k * SEG));
    assign c_d[k] = seg_sum[SEG];
    assign v_d[k] = v_src;
    assign a_d[k] = a_src;
    assign b_d[k] = b_src;

    if (k == STAGES - 1) begin : g_tail
      assign ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (s_d[k][WIDTH-1] != a_src[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_carry_adder.sv
// Directed and scoreboarded checks of pipelined_ripple_carry_adder at 32/4,
// plus streamed sweeps at 8/1, 16/8 and 64/2.
module tb_pipelined_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, overflow;
  logic        sweep_go = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic        sv [4];
  logic [65:0] se [4];

  always #5 clk = ~clk;

  pipelined_ripple_carry_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, sum} for a w-bit add/sub, built from unsigned
  // compare and signed range tests rather than the inverted-operand form.
  function automatic logic [65:0] model(input int unsigned w, input logic [63:0] a_i,
                                        input logic [63:0] b_i, input logic c_i, input logic s_i);
    logic [63:0] mask, s;
    logic [64:0] u;
    logic [65:0] sa, sb, r, lim;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a_i  = a_i & mask;
    b_i  = b_i & mask;
    u    = {1'b0, a_i} + {1'b0, b_i} + 65'(c_i);
    if (s_i) begin
      s  = (a_i - b_i) & mask;
      co = (a_i >= b_i);
    end else begin
      s  = u[63:0] & mask;
      co = u[w];
    end
    sa = {2'b0, a_i};
    sb = {2'b0, b_i};
    if (a_i[w-1]) sa = sa - (66'd1 << w);
    if (b_i[w-1]) sb = sb - (66'd1 << w);
    r   = s_i ? (sa - sb) : (sa + sb + 66'(c_i));
    lim = 66'd1 << (w - 1);
    ov  = ($signed(r) >= $signed(lim)) || ($signed(r) < -$signed(lim));
    return {ov, co, s};
  endfunction

  task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tc, input logic ts, input logic [31:0] es,
                            input logic ec, input logic eo);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 4) begin
        check({tag, "_early"}, 66'(out_valid), 66'(0));
      end else begin
        check({tag, "_valid"}, 66'(out_valid), 66'(1));
        check({tag, "_res"}, {overflow, cout, 32'h0, sum}, {eo, ec, 32'h0, es});
      end
    end
  endtask

  task automatic run_stream(input string tag, input int nops, input int stall_at);
    int   sent, got;
    logic adv;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0;
      se[i] = '0;
    end
    for (int cyc = 0; cyc < 200 && got < nops; cyc++) begin
      @(negedge clk);
      check({tag, "_ov"}, 66'(out_valid), 66'(sv[3]));
      if (sv[3]) check({tag, "_res"}, {overflow, cout, 32'h0, sum}, se[3]);
      out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
      #1;
      adv = !sv[3] || out_ready;
      check({tag, "_rdy"}, 66'(in_ready), 66'(adv));
      if (out_valid && out_ready) got++;
      if (sent < nops) begin
        in_valid = 1'b1;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
      end else begin
        in_valid = 1'b0;
      end
      if (adv) begin
        sv[3] = sv[2]; se[3] = se[2];
        sv[2] = sv[1]; se[2] = se[1];
        sv[1] = sv[0]; se[1] = se[0];
        sv[0] = in_valid;
        se[0] = model(32, {32'h0, a}, {32'h0, b}, cin, sub);
        if (in_valid) sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 66'(got), 66'(nops));
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 8 : 2;
    logic         iv, ir, ov, orr, ci, sb, co, of, done;
    logic [W-1:0] xa, xb, xs;
    logic [65:0]  q_exp [$];
    int           q_cyc [$];

    pipelined_ripple_carry_adder #(.WIDTH(W), .STAGES(S)) u_sweep (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(xa), .b(xb), .cin(ci), .sub(sb), .out_valid(ov),
      .out_ready(orr), .sum(xs), .cout(co), .overflow(of)
    );

    initial begin
      int          sent;
      logic        exp_v;
      logic [63:0] ra, rb;
      iv = 1'b0; orr = 1'b1; ci = 1'b0; sb = 1'b0; done = 1'b0;
      xa = '0; xb = '0;
      sent = 0;
      wait (sweep_go);
      for (int c = 0; c < 4000 && (sent < 1000 || q_exp.size() != 0); c++) begin
        @(negedge clk);
        exp_v = (q_cyc.size() != 0) && (q_cyc[0] + int'(S) == c);
        check("sweep_valid", 66'(ov), 66'(exp_v));
        if (exp_v) begin
          check("sweep_res", {of, co, 64'(xs)}, q_exp.pop_front());
          void'(q_cyc.pop_front());
        end
        iv = (sent < 1000) && ($urandom_range(3) != 0);
        if (iv) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          xa = ra[W-1:0];
          xb = rb[W-1:0];
          ci = 1'($urandom_range(1));
          sb = 1'($urandom_range(1));
          q_exp.push_back(model(W, 64'(xa), 64'(xb), ci, sb));
          q_cyc.push_back(c);
          sent++;
        end
      end
      iv   = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    logic [2:0] all_done;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_async", {out_valid, overflow, cout, 31'h0, sum}, '0);
    repeat (2) @(negedge clk);
    check("rst_hold", {out_valid, overflow, cout, 31'h0, sum}, '0);
    rst_n = 1'b1;
    #1 check("rst_ready", 66'(in_ready), 66'(1));

    run_single("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("add_cin_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("add_seg",   32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_single("sub_zero",  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    run_stream("stream", 16, 1000);
    run_stream("stall", 16, 8);

    // Five ops launched: one at the output, three still in flight at reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h100 + 32'(i);
      b = 32'h1;
      cin = 1'b0; sub = 1'b0;
    end
    @(posedge clk);
    in_valid = 1'b0;
    #2 check("pre_rst_valid", 66'(out_valid), 66'(1));
    rst_n = 1'b0;
    #1 check("mid_rst_drop", {out_valid, overflow, cout, 31'h0, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale", 66'(out_valid), 66'(0));
    end
    run_single("post_rst", 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    @(negedge clk);
    sweep_go = 1'b1;
    all_done = 3'b000;
    for (int t = 0; t < 8000 && all_done != 3'b111; t++) begin
      @(negedge clk);
      all_done = {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done};
    end
    check("sweep_done", 66'(all_done), 66'(3'b111));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
